ser_add_seq: RTL and testbench
==============================

Name: ser_add_seq

Overview:
- Operand sequencer/collector directly around the bit-serial adder (ser_add).
- Accepts two parallel WIDTH-bit operands over a valid/ready handshake and streams them LSB-first into the adder's a/b inputs, driving clr on the first bit.
- Deserializes the adder's registered sum bit q back into a parallel result and captures the final carry o_v.
- Presents result plus carry-out downstream over a valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low; 0 forces the reset state immediately.
- i_valid  input  1  operand pair valid.
- o_ready  output  1  block can accept operands.
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- o_add_a  output  1  serial bit to adder input a.
- o_add_b  output  1  serial bit to adder input b.
- o_add_clr  output  1  to adder clr; forces carry-in 0.
- i_add_q  input  1  adder registered sum bit (q).
- i_add_cy  input  1  adder registered carry (o_v).
- o_res_valid  output  1  result valid.
- i_res_ready  input  1  downstream accepts result.
- o_res  output  WIDTH  sum, (i_a + i_b) mod 2^WIDTH.
- o_cout  output  1  unsigned carry-out of the sum.

Behaviour:
- Adder timing contract: bits presented on a/b/clr in cycle t produce q and o_v in cycle t+1.
- States:
  - IDLE: o_ready=1.
  - SHIFT: WIDTH cycles, bit counter 0..WIDTH-1.
  - CAPTURE: 1 cycle.
  - DONE: o_res_valid=1.
- Reset (rst=0): state=IDLE, counter=0, operand shift registers=0, result register=0, o_cout=0, o_res_valid=0, o_add_a=0, o_add_b=0, o_add_clr=1. o_ready reads 1 once rst=1.
- IDLE→SHIFT when i_valid&&o_ready (cycle T). Latch i_a, i_b. Counter=0.
- SHIFT, counter k, cycle T+1+k:
  - o_add_a=A[k], o_add_b=B[k].
  - o_add_clr=1 only when k=0, else 0.
  - For k>=1, shift i_add_q into result MSB end (shift right); this is sum bit k-1.
- SHIFT with k=WIDTH-1 → CAPTURE.
- CAPTURE, cycle T+1+WIDTH:
  - Shift i_add_q in as sum bit WIDTH-1.
  - Latch i_add_cy into o_cout.
  - Go to DONE.
- Shift direction is fixed so that sum bit 0 ends in o_res[0].
- DONE from cycle T+2+WIDTH:
  - o_res_valid=1; o_res and o_cout stable until handshake.
  - i_res_ready=1 → IDLE next cycle.
  - o_ready=0 in DONE; no same-cycle re-accept.
- Total latency: accept to o_res_valid = WIDTH+2 cycles. Max throughput: one operation per WIDTH+3 cycles.
- Outside SHIFT: o_add_a=0, o_add_b=0, o_add_clr=1 (adder held cleared).
- o_ready=0 in SHIFT/CAPTURE/DONE. i_valid is ignored there; operand inputs are not sampled.
- i_res_ready outside DONE is ignored.
- Counter is $clog2(WIDTH) bits wide and never wraps past WIDTH-1.
- rst=0 mid-operation: in-flight operation is discarded, no partial result is flagged, block returns to IDLE.
- Downstream holding i_res_ready=0 indefinitely: remain in DONE with outputs frozen.

Optional Feature:
- Macro SER_ADD_SEQ_OVF_EN.
- When defined:
  - Add output o_ovf (1 bit), reset 0, latched in CAPTURE.
  - o_ovf = (A[WIDTH-1]==B[WIDTH-1]) && (i_add_q != A[WIDTH-1]), i.e. two's-complement signed overflow.
  - Valid and stable with o_res_valid.
- When undefined: port o_ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=32, i_a=5, i_b=3, i_res_ready=1 → o_res_valid at T+34, o_res=8, o_cout=0; o_add_clr high only at T+1 within SHIFT.
- i_a=FFFFFFFF, i_b=00000001 → o_res=0, o_cout=1 (o_ovf=0 if enabled).
- i_a=7FFFFFFF, i_b=00000001 with SER_ADD_SEQ_OVF_EN → o_res=80000000, o_cout=0, o_ovf=1.
- Backpressure: i_res_ready=0 for 10 cycles after o_res_valid → o_res/o_cout stable, o_ready=0, new i_valid ignored. Then ready=1 → IDLE, o_ready=1 next cycle.
- Back-to-back: i_valid held high with 1+2 then 10+20 → results 3 then 30. Second accept exactly 1 cycle after first result handshake.
- rst=0 at T+10 mid-SHIFT → immediately o_res_valid=0, o_add_clr=1. After release, o_ready=1; a fresh 4+4 yields 8.

Source files
------------

// File: rtl/ser_add_seq_if.sv
// Bundle of operand handshake, serial adder link and result handshake for ser_add_seq.
// Optional o_ovf is present only when SER_ADD_SEQ_OVF_EN is defined.
interface ser_add_seq_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_add_a;
    logic             o_add_b;
    logic             o_add_clr;
    logic             i_add_q;
    logic             i_add_cy;
    logic             o_res_valid;
    logic             i_res_ready;
    logic [WIDTH-1:0] o_res;
    logic             o_cout;
`ifdef SER_ADD_SEQ_OVF_EN
    logic             o_ovf;
`endif

    modport slave (
        input  i_valid, i_a, i_b, i_add_q, i_add_cy, i_res_ready,
`ifdef SER_ADD_SEQ_OVF_EN
        output o_ovf,
`endif
        output o_ready, o_add_a, o_add_b, o_add_clr, o_res_valid, o_res, o_cout
    );

    modport master (
        output i_valid, i_a, i_b, i_add_q, i_add_cy, i_res_ready,
`ifdef SER_ADD_SEQ_OVF_EN
        input  o_ovf,
`endif
        input  o_ready, o_add_a, o_add_b, o_add_clr, o_res_valid, o_res, o_cout
    );
endinterface

// File: rtl/ser_add_seq.sv
// Operand sequencer/collector around a registered bit-serial adder: streams operands LSB-first,
// deserializes the sum and carry-out. Macro SER_ADD_SEQ_OVF_EN adds a signed-overflow flag.
module ser_add_seq #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    ser_add_seq_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] res_reg, res_next;
    logic             cout_reg, cout_next;
    logic [WIDTH-1:0] res_shifted;
`ifdef SER_ADD_SEQ_OVF_EN
    logic             ovf_reg, ovf_next;
`endif

    // Adder output enters at the MSB so that sum bit 0 lands in bit 0 after WIDTH shifts.
    assign res_shifted[WIDTH-1] = bus.i_add_q;
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign res_shifted[gi] = res_reg[gi+1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            cout_reg  <= 1'b0;
`ifdef SER_ADD_SEQ_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            res_reg   <= res_next;
            cout_reg  <= cout_next;
`ifdef SER_ADD_SEQ_OVF_EN
            ovf_reg   <= ovf_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        a_next          = a_reg;
        b_next          = b_reg;
        res_next        = res_reg;
        cout_next       = cout_reg;
`ifdef SER_ADD_SEQ_OVF_EN
        ovf_next        = ovf_reg;
`endif
        bus.o_ready     = 1'b0;
        bus.o_res_valid = 1'b0;
        bus.o_add_a     = 1'b0;
        bus.o_add_b     = 1'b0;
        bus.o_add_clr   = 1'b1;

        case (state_reg)
            IDLE: begin
                bus.o_ready = 1'b1;
                if (bus.i_valid) begin
                    state_next = SHIFT;
                    a_next     = bus.i_a;
                    b_next     = bus.i_b;
                    cnt_next   = '0;
                end
            end
            SHIFT: begin
                bus.o_add_a   = a_reg[cnt_reg];
                bus.o_add_b   = b_reg[cnt_reg];
                bus.o_add_clr = (cnt_reg == '0);
                // The adder is one cycle behind, so bit k-1 arrives while bit k is presented.
                if (cnt_reg != '0) begin
                    res_next = res_shifted;
                end
                if (cnt_reg == LAST) begin
                    state_next = CAPTURE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            CAPTURE: begin
                res_next   = res_shifted;
                cout_next  = bus.i_add_cy;
`ifdef SER_ADD_SEQ_OVF_EN
                ovf_next   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (bus.i_add_q != a_reg[WIDTH-1]);
`endif
                state_next = DONE;
            end
            DONE: begin
                bus.o_res_valid = 1'b1;
                if (bus.i_res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.o_res  = res_reg;
    assign bus.o_cout = cout_reg;
`ifdef SER_ADD_SEQ_OVF_EN
    assign bus.o_ovf  = ovf_reg;
`endif
endmodule

// File: tb/tb_ser_add_seq.sv
// Self-checking bench for ser_add_seq with a behavioural registered serial adder and a result scoreboard.
module tb_ser_add_seq;
    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    ser_add_seq_if #(.WIDTH(WIDTH)) bus ();

    ser_add_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered serial adder: bits in cycle t give sum/carry in cycle t+1.
    logic       add_q  = 1'b0;
    logic       add_cy = 1'b0;
    logic [1:0] add_sum;
    assign add_sum = {1'b0, bus.o_add_a} + {1'b0, bus.o_add_b} + {1'b0, (bus.o_add_clr ? 1'b0 : add_cy)};
    always @(posedge clk) begin
        add_q  <= add_sum[0];
        add_cy <= add_sum[1];
    end
    assign bus.i_add_q  = add_q;
    assign bus.i_add_cy = add_cy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic offer(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.i_valid = 1'b1;
        bus.i_a     = a;
        bus.i_b     = b;
    endtask

    // Called at a negedge with i_valid high; returns at the negedge of cycle T+1.
    task automatic wait_accept();
        int   n;
        exp_t e;
        logic [WIDTH:0] full;
        n = 0;
        while (!bus.o_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", bus.o_ready, 1);
        full   = {1'b0, bus.i_a} + {1'b0, bus.i_b};
        e.res  = full[WIDTH-1:0];
        e.cout = full[WIDTH];
        e.ovf  = (bus.i_a[WIDTH-1] == bus.i_b[WIDTH-1]) && (full[WIDTH-1] != bus.i_a[WIDTH-1]);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic wait_valid(output int lat, output int clr_first, output int clr_cnt);
        lat       = 1;
        clr_cnt   = 0;
        clr_first = int'(bus.o_add_clr);
        while (!bus.o_res_valid && lat < 200) begin
            if (lat <= WIDTH && bus.o_add_clr) clr_cnt++;
            @(negedge clk);
            lat++;
        end
        check("res_valid", bus.o_res_valid, 1);
    endtask

    task automatic take(input string tag);
        exp_t e;
        check({tag, "_sb_depth"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_res"}, bus.o_res, e.res);
            check({tag, "_cout"}, bus.o_cout, e.cout);
`ifdef SER_ADD_SEQ_OVF_EN
            check({tag, "_ovf"}, bus.o_ovf, e.ovf);
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] va [8];
        logic [WIDTH-1:0] vb [8];
        logic [WIDTH-1:0] held_res;
        logic             held_cout;
        int lat, clr_first, clr_cnt;

        va[0] = 32'h5;        vb[0] = 32'h3;
        va[1] = 32'hFFFFFFFF; vb[1] = 32'h1;
        va[2] = 32'h7FFFFFFF; vb[2] = 32'h1;
        va[3] = 32'h80000000; vb[3] = 32'h80000000;
        for (int i = 4; i < 8; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom;
        end

        rst             = 1'b0;
        bus.i_valid     = 1'b0;
        bus.i_a         = '0;
        bus.i_b         = '0;
        bus.i_res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_res_valid", bus.o_res_valid, 0);
        check("rst_clr", bus.o_add_clr, 1);
        check("rst_add_a", bus.o_add_a, 0);
        check("rst_add_b", bus.o_add_b, 0);
        check("rst_res", bus.o_res, 0);
        check("rst_cout", bus.o_cout, 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_ready", bus.o_ready, 1);

        bus.i_res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            offer(va[i], vb[i]);
            wait_accept();
            bus.i_valid = 1'b0;
            wait_valid(lat, clr_first, clr_cnt);
            check($sformatf("op%0d_latency", i), lat, WIDTH + 2);
            check($sformatf("op%0d_clr_first", i), clr_first, 1);
            check($sformatf("op%0d_clr_count", i), clr_cnt, 1);
            take($sformatf("op%0d", i));
            @(negedge clk);
            check($sformatf("op%0d_ready_after", i), bus.o_ready, 1);
        end

        // Backpressure: result must freeze and new operands must be ignored.
        bus.i_res_ready = 1'b0;
        offer(32'h12345678, 32'h11111111);
        wait_accept();
        bus.i_valid = 1'b0;
        wait_valid(lat, clr_first, clr_cnt);
        held_res  = bus.o_res;
        held_cout = bus.o_cout;
        offer(32'hDEADBEEF, 32'h0BADF00D);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_valid", bus.o_res_valid, 1);
            check("bp_ready", bus.o_ready, 0);
            check("bp_res_stable", bus.o_res, held_res);
            check("bp_cout_stable", bus.o_cout, held_cout);
        end
        bus.i_valid     = 1'b0;
        bus.i_res_ready = 1'b1;
        take("bp");
        @(negedge clk);
        check("bp_ready_after", bus.o_ready, 1);
        check("bp_valid_after", bus.o_res_valid, 0);

        // Back-to-back with i_valid held high.
        offer(32'd1, 32'd2);
        wait_accept();
        offer(32'd10, 32'd20);
        wait_valid(lat, clr_first, clr_cnt);
        take("b2b_first");
        @(negedge clk);
        check("b2b_reaccept_ready", bus.o_ready, 1);
        wait_accept();
        bus.i_valid = 1'b0;
        wait_valid(lat, clr_first, clr_cnt);
        check("b2b_second_latency", lat, WIDTH + 2);
        take("b2b_second");
        @(negedge clk);

        // Reset in the middle of SHIFT discards the operation.
        offer(32'd9, 32'd9);
        wait_accept();
        bus.i_valid = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_valid", bus.o_res_valid, 0);
        check("midrst_clr", bus.o_add_clr, 1);
        check("midrst_add_a", bus.o_add_a, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", bus.o_ready, 1);
        check("midrst_res", bus.o_res, 0);
        offer(32'd4, 32'd4);
        wait_accept();
        bus.i_valid = 1'b0;
        wait_valid(lat, clr_first, clr_cnt);
        check("midrst_op_latency", lat, WIDTH + 2);
        check("midrst_op_res_is_8", bus.o_res, 8);
        take("midrst_op");
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
